// File: rtl/mem_pkg.sv
// Shared definitions for the data memory unit and its MemoryController peer.
// State encoding, RW polarity, word size and the load/store opcodes.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERROR  = 2'd3
    } dmem_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int unsigned WORD_BYTES = 4;

    localparam logic [3:0] OP_LDR = 4'hA;
    localparam logic [3:0] OP_STR = 4'hB;

    // Misaligned or beyond the last word: the access is rejected.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/acknowledge bus between the MemoryController (master) and the data memory (slave).
// Carries request, direction, address, store data, and the completion/status signals back.
interface data_memory_unit_if;
    logic        Req;
    logic        RW;
    logic [31:0] AddressBus;
    logic [31:0] DataBus;
    logic [31:0] ReadData;
    logic        Ack;
    logic        Busy;
    logic        AddrError;

    modport master (
        output Req, RW, AddressBus, DataBus,
        input  ReadData, Ack, Busy, AddrError
    );

    modport slave (
        input  Req, RW, AddressBus, DataBus,
        output ReadData, Ack, Busy, AddrError
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 storage with write enable and registered read.
// Latency: read data valid the cycle after re_i; no backpressure, one access per cycle.
// Contents are never reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdat_i,
    output logic [31:0]   rdat_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdat_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdat_i;
        end
        if (re_i) begin
            rdat_q <= mem_q[addr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/data_memory_unit.sv
// Word-addressed data memory behind the MemoryController with WAIT_STATES wait cycles.
// Latency: Ack after E0+WAIT_STATES+1 (valid) or E0+1 (address error).
// Backpressure: Busy high while an access is in flight; Req during Busy is dropped.
module data_memory_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    data_memory_unit_if.slave   bus
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_t  state_q;
    logic [3:0]   cnt_q;
    logic         rw_q;
    logic [AW-1:0] idx_q;
    logic [31:0]  wdat_q;
    logic [31:0]  rdata_q;
    logic         ack_q;
    logic         busy_q;
    logic         err_q;

    logic          req_bad;
    logic [AW-1:0] req_idx;
    logic          arr_we;
    logic          arr_re;
    logic [AW-1:0] arr_addr;
    logic [31:0]   arr_rdat;

    assign req_bad = addr_bad(bus.AddressBus, DEPTH_WORDS);
    assign req_idx = bus.AddressBus[2 +: AW];

    // The array read is issued on the edge entering ACCESS so its registered
    // output is ready when ACCESS retires; no write can intervene in between.
    always_comb begin
        arr_re   = 1'b0;
        arr_we   = 1'b0;
        arr_addr = idx_q;
        case (state_q)
            ST_IDLE: begin
                arr_addr = req_idx;
                arr_re   = bus.Req && !req_bad && (WAIT_STATES == 0) && (bus.RW == RW_READ);
            end
            ST_WAIT:   arr_re = (cnt_q == 4'd0) && (rw_q == RW_READ);
            ST_ACCESS: arr_we = (rw_q == RW_WRITE);
            default:   ;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk    (clk),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .addr_i (arr_addr),
        .wdat_i (wdat_q),
        .rdat_o (arr_rdat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= RW_WRITE;
            idx_q   <= '0;
            wdat_q  <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.Req) begin
                        rw_q   <= bus.RW;
                        idx_q  <= req_idx;
                        wdat_q <= bus.DataBus;
                        busy_q <= 1'b1;
                        if (req_bad) begin
                            state_q <= ST_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state_q <= ST_ACCESS;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
                    if (rw_q == RW_READ) begin
                        rdata_q <= arr_rdat;
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
                    err_q   <= 1'b1;
                    rdata_q <= 32'd0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ReadData  = rdata_q;
    assign bus.Ack       = ack_q;
    assign bus.Busy      = busy_q;
    assign bus.AddrError = err_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed vectors, corner sequences and
// randomized traffic against a word-array reference model.
module tb_data_memory_unit;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WS    = 2;

    logic clk;
    logic rst_n;
    data_memory_unit_if bus ();

    data_memory_unit #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_rd;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic mdl_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic void mdl_apply(input logic rw, input logic [31:0] a, input logic [31:0] d);
        if (mdl_bad(a)) begin
            mdl_rd = 32'd0;
        end else if (rw) begin
            mdl_rd = mdl_mem[a / 4];
        end else begin
            mdl_mem[a / 4] = d;
        end
    endfunction

    // One complete transaction; lat = edges from accept to the edge raising Ack, -1 on timeout.
    task automatic op(input logic rw, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat, output logic busy_ok);
        @(negedge clk);
        bus.Req = 1'b1; bus.RW = rw; bus.AddressBus = a; bus.DataBus = d;
        @(posedge clk);
        @(negedge clk);
        bus.Req = 1'b0; bus.RW = ~rw; bus.AddressBus = $urandom; bus.DataBus = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.Ack && lat < 50) begin
            if (!bus.Busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!bus.Ack) lat = -1;
        if (bus.Busy) busy_ok = 1'b0;
        rd = bus.ReadData;
        er = bus.AddrError;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        bok;
        int          acks;
        logic [31:0] a;
        logic [31:0] d;
        logic        rw;
        logic        exp_er;

        bus.Req = 1'b0; bus.RW = 1'b0; bus.AddressBus = 32'd0; bus.DataBus = 32'd0;
        mdl_rd = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_readdata", bus.ReadData, 32'd0);
        chk("reset_ack", {31'd0, bus.Ack}, 32'd0);
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_adderr", {31'd0, bus.AddrError}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            d = $urandom;
            op(1'b0, 32'(i * 4), d, rd, er, lat, bok);
            mdl_apply(1'b0, 32'(i * 4), d);
        end

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h9ABC_DEF0};
        vecs[2] = '{1'b1, 32'h1234_5679, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h9ABC_DEF0};
        vecs[4] = '{1'b0, 32'h0000_0400, 32'h5555_AAAA, 1'b1, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_03FC, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 32'h0000_03FC, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 32'h0000_0400, 32'h0,         1'b1, 1'b1, 32'h0};

        for (int i = 0; i < 8; i++) begin
            op(vecs[i].rw, vecs[i].addr, vecs[i].data, rd, er, lat, bok);
            mdl_apply(vecs[i].rw, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_lat", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'(WS + 1));
            chk($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end

        // Back-to-back: Req stays high across the write's Ack cycle with a read queued behind it.
        @(negedge clk);
        bus.Req = 1'b1; bus.RW = 1'b0; bus.AddressBus = 32'h40; bus.DataBus = 32'hC0FF_EE01;
        @(posedge clk);
        @(negedge clk);
        bus.RW = 1'b1;
        lat = 0;
        while (!bus.Ack && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_wr_lat", 32'(lat), 32'(WS + 1));
        chk("b2b_ackcycle_busy", {31'd0, bus.Busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.Req = 1'b0;
        chk("b2b_rd_accepted", {31'd0, bus.Busy}, 32'd1);
        lat = 0;
        while (!bus.Ack && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_rd_lat", 32'(lat), 32'(WS + 1));
        chk("b2b_rd_data", bus.ReadData, 32'hC0FF_EE01);
        mdl_apply(1'b0, 32'h40, 32'hC0FF_EE01);
        mdl_apply(1'b1, 32'h40, 32'h0);
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.Ack || bus.Busy) acks++;
        end
        chk("b2b_no_extra_access", 32'(acks), 32'd0);

        // Reset abort of a write in WAIT.
        op(1'b0, 32'h20, 32'h2222_2222, rd, er, lat, bok);
        mdl_apply(1'b0, 32'h20, 32'h2222_2222);
        op(1'b1, 32'h20, 32'h0, rd, er, lat, bok);
        mdl_apply(1'b1, 32'h20, 32'h0);
        chk("abort_pre_read", rd, 32'h2222_2222);
        @(negedge clk);
        bus.Req = 1'b1; bus.RW = 1'b0; bus.AddressBus = 32'h20; bus.DataBus = 32'h1111_1111;
        @(posedge clk);
        #2;
        bus.Req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_readdata", bus.ReadData, 32'd0);
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_ack", {31'd0, bus.Ack}, 32'd0);
        chk("abort_adderr", {31'd0, bus.AddrError}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_rd = 32'd0;
        op(1'b1, 32'h20, 32'h0, rd, er, lat, bok);
        mdl_apply(1'b1, 32'h20, 32'h0);
        chk("abort_post_read", rd, 32'h2222_2222);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                2:       a = 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
                default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            d = $urandom;
            exp_er = mdl_bad(a);
            op(rw, a, d, rd, er, lat, bok);
            mdl_apply(rw, a, d);
            chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, exp_er});
            chk($sformatf("rnd%0d_lat", i), 32'(lat), exp_er ? 32'd1 : 32'(WS + 1));
            chk($sformatf("rnd%0d_busy", i), {31'd0, bok}, 32'd1);
            chk($sformatf("rnd%0d_rd", i), rd, mdl_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
